// File: rtl/shift_sequencer_pkg.sv
// shift_sequencer_pkg: shared encodings and helpers for the shift sequencer
package shift_sequencer_pkg;

    localparam int WIDTH      = 8;
    localparam int MAX_AMOUNT = 8;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        SHIFT_LOGICAL = 2'b00,
        SHIFT_ONES    = 2'b01,
        SHIFT_ROTATE  = 2'b10,
        SHIFT_ARITH   = 2'b11
    } shift_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    // Shift counts beyond the operand width behave like a full-width shift
    function automatic logic [3:0] sat_amount(input logic [3:0] a);
        return (a > 4'(MAX_AMOUNT)) ? 4'(MAX_AMOUNT) : a;
    endfunction

endpackage

// File: rtl/shift_8_bit.sv
// shift_8_bit: stateless single-step shifter, one position left or right per use
module shift_8_bit (
    input  logic [7:0] d,
    input  logic       select,
    input  logic       shift_in_left,
    input  logic       shift_in_right,
    output logic [7:0] s,
    output logic       bb_left,
    output logic       bb_right
);

    // select=0 moves toward bit 7, select=1 moves toward bit 0
    assign s        = select ? {shift_in_left, d[7:1]} : {d[6:0], shift_in_right};
    assign bb_left  = d[7];
    assign bb_right = d[0];

endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: drives the single-step shifter once per clock to build a barrel shift
module shift_sequencer
    import shift_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic             dir,
    input  logic [3:0]       amount,
    input  logic [1:0]       mode,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    state_t           state, next_state;
    shift_mode_t      mode_q;
    logic [WIDTH-1:0] work, shifted;
    logic [3:0]       count;
    logic             dir_q, work_carry, settle, fill, bb_left, bb_right;

    shift_8_bit u_shifter (
        .d              (work),
        .select         (dir_q),
        .shift_in_left  (fill),
        .shift_in_right (fill),
        .s              (shifted),
        .bb_left        (bb_left),
        .bb_right       (bb_right)
    );

    // Fill bit entering the vacated end, chosen by the latched mode and direction
    always_comb begin
        fill = 1'b0;
        case (mode_q)
            SHIFT_ONES:   fill = 1'b1;
            SHIFT_ROTATE: fill = (dir_q == DIR_RIGHT) ? work[0] : work[WIDTH-1];
            SHIFT_ARITH:  fill = (dir_q == DIR_RIGHT) ? work[WIDTH-1] : 1'b0;
            default:      fill = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next state; DONE spans a commit cycle followed by the done cycle
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = start ? ((sat_amount(amount) == 4'd0) ? DONE : SHIFT) : IDLE;
            SHIFT:   next_state = (count == 4'd1) ? DONE : SHIFT;
            DONE:    next_state = settle ? DONE : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state
    always_comb begin
        ready = (state == IDLE);
        busy  = (state == SHIFT);
        done  = (state == DONE) && !settle;
    end

    // Operand capture, per-step shifting and result commit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            work       <= '0;
            count      <= '0;
            dir_q      <= DIR_LEFT;
            mode_q     <= SHIFT_LOGICAL;
            work_carry <= 1'b0;
            settle     <= 1'b0;
            result     <= '0;
            carry      <= 1'b0;
        end else begin
            settle <= (state != DONE) && (next_state == DONE);
            if (state == IDLE && start) begin
                work       <= data_in;
                count      <= sat_amount(amount);
                dir_q      <= dir;
                mode_q     <= shift_mode_t'(mode);
                work_carry <= 1'b0;
            end
            if (state == SHIFT) begin
                work       <= shifted;
                work_carry <= (dir_q == DIR_LEFT) ? bb_left : bb_right;
                count      <= count - 4'd1;
            end
            if (state == DONE && settle) begin
                result <= work;
                carry  <= work_carry;
            end
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: randomized and directed checks against a behavioural shift model
module tb_shift_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       dir = 1'b0;
    logic [3:0] amount = 4'd0;
    logic [1:0] mode = 2'b00;
    logic       ready, busy, done, carry;
    logic [7:0] result;

    int checks = 0;
    int failures = 0;

    shift_sequencer dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .data_in (data_in),
        .dir     (dir),
        .amount  (amount),
        .mode    (mode),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .carry   (carry)
    );

    always #5 clk = ~clk;

    // Whole-operation model: closed-form shift by n with the mode's fill rule
    task automatic model(input logic [7:0] d, input logic dr, input logic [3:0] a,
                         input logic [1:0] m, output logic [7:0] r, output logic c);
        int n;
        logic [15:0] w;
        n = (a > 8) ? 8 : int'(a);
        if (n == 0) begin
            r = d;
            c = 1'b0;
        end else if (!dr) begin
            w = {d, d} << n;
            c = d[8-n];
            case (m)
                2'b01:   r = (d << n) | 8'((16'd1 << n) - 16'd1);
                2'b10:   r = w[15:8];
                default: r = d << n;
            endcase
        end else begin
            w = {d, d} >> n;
            c = d[n-1];
            case (m)
                2'b01:   r = (d >> n) | ~(8'hFF >> n);
                2'b10:   r = w[7:0];
                2'b11:   r = 8'($signed(d) >>> n);
                default: r = d >> n;
            endcase
        end
    endtask

    // Issue one request from a negedge with ready=1; returns at the negedge where done is seen
    task automatic run_op(input logic [7:0] d, input logic dr, input logic [3:0] a,
                          input logic [1:0] m, output int lat, output int busy_cyc,
                          output logic timeout, output logic held_changed);
        logic [7:0] prev;
        prev = result;
        data_in = d; dir = dr; amount = a; mode = m; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        data_in = 8'($urandom); dir = 1'($urandom); amount = 4'($urandom); mode = 2'($urandom);
        lat = 0; busy_cyc = 0; held_changed = 1'b0;
        while (!done && lat < 40) begin
            if (busy) busy_cyc++;
            if (result !== prev) held_changed = 1'b1;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        timeout = !done;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({ready, busy, done, result, carry} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0}) begin
            failures++;
            $display("FAIL reset_state: got ready=%b busy=%b done=%b result=%h carry=%b, want 1 0 0 00 0",
                     ready, busy, done, result, carry);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Spec vectors: operand, dir, amount, mode
    task automatic test_directed();
        logic [7:0] vd[6] = '{8'hB5, 8'h90, 8'h90, 8'h81, 8'h81, 8'h3C};
        logic       vr[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [3:0] va[6] = '{4'd3, 4'd2, 4'd4, 4'd1, 4'd12, 4'd0};
        logic [1:0] vm[6] = '{2'b00, 2'b11, 2'b01, 2'b10, 2'b10, 2'b00};
        logic [7:0] vx[6] = '{8'hA8, 8'hE4, 8'hF9, 8'h03, 8'h81, 8'h3C};
        logic       vc[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        int         vl[6] = '{4, 3, 5, 2, 9, 1};
        int         vb[6] = '{3, 2, 4, 1, 8, 0};
        int lat, bc;
        logic to, hc;
        for (int i = 0; i < 6; i++) begin
            run_op(vd[i], vr[i], va[i], vm[i], lat, bc, to, hc);
            checks++;
            if (to || result !== vx[i] || carry !== vc[i]) begin
                failures++;
                $display("FAIL directed_%0d: got result=%h carry=%b timeout=%b, want %h %b",
                         i, result, carry, to, vx[i], vc[i]);
            end
            checks++;
            if (lat != vl[i] || bc != vb[i]) begin
                failures++;
                $display("FAIL directed_timing_%0d: got latency=%0d busy=%0d, want %0d %0d",
                         i, lat, bc, vl[i], vb[i]);
            end
            checks++;
            if (ready !== 1'b0 || hc) begin
                failures++;
                $display("FAIL directed_handshake_%0d: got ready=%b early_change=%b at done, want 0 0", i, ready, hc);
            end
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || ready !== 1'b1) begin
                failures++;
                $display("FAIL directed_pulse_%0d: got done=%b ready=%b after done, want 0 1", i, done, ready);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] d, er;
        logic       dr, ec, to, hc;
        logic [3:0] a;
        logic [1:0] m;
        int lat, bc, n;
        for (int i = 0; i < 40; i++) begin
            d = 8'($urandom); dr = 1'($urandom); a = 4'($urandom); m = 2'($urandom);
            model(d, dr, a, m, er, ec);
            n = (a > 8) ? 8 : int'(a);
            run_op(d, dr, a, m, lat, bc, to, hc);
            checks++;
            if (to || result !== er || carry !== ec || lat != n + 1 || bc != n) begin
                failures++;
                $display("FAIL random_%0d d=%h dir=%b amt=%0d mode=%0d: got result=%h carry=%b lat=%0d busy=%0d, want %h %b %0d %0d",
                         i, d, dr, a, m, result, carry, lat, bc, er, ec, n + 1, n);
            end
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic test_ignored_start();
        logic [7:0] er;
        logic       ec;
        int lat;
        int bsy;
        model(8'h5A, 1'b0, 4'd5, 2'b10, er, ec);
        data_in = 8'h5A; dir = 1'b0; amount = 4'd5; mode = 2'b10; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        data_in = 8'hFF; dir = 1'b1; amount = 4'd1; mode = 2'b01; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 2;
        while (!done && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        checks++;
        if (!done || result !== er || carry !== ec || lat != 6) begin
            failures++;
            $display("FAIL ignored_start: got result=%h carry=%b lat=%0d, want %h %b 6", result, carry, lat, er, ec);
        end
        bsy = 0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            if (busy || !ready) bsy++;
        end
        checks++;
        if (bsy != 0) begin
            failures++;
            $display("FAIL ignored_no_queue: got %0d non-idle cycles after done, want 0", bsy);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] r1, r2, e1, e2;
        logic       c1, c2, to, hc;
        int lat, bc;
        model(8'hC3, 1'b1, 4'd3, 2'b11, e1, c1);
        model(8'h1E, 1'b0, 4'd2, 2'b01, e2, c2);
        run_op(8'hC3, 1'b1, 4'd3, 2'b11, lat, bc, to, hc);
        r1 = result;
        checks++;
        if (to || r1 !== e1 || carry !== c1) begin
            failures++;
            $display("FAIL b2b_first: got result=%h carry=%b, want %h %b", r1, carry, e1, c1);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_ready: got ready=%b in cycle after done, want 1", ready);
        end
        run_op(8'h1E, 1'b0, 4'd2, 2'b01, lat, bc, to, hc);
        r2 = result;
        checks++;
        if (to || r2 !== e2 || carry !== c2 || lat != 3) begin
            failures++;
            $display("FAIL b2b_second: got result=%h carry=%b lat=%0d, want %h %b 3", r2, carry, lat, e2, c2);
        end
        checks++;
        if (hc) begin
            failures++;
            $display("FAIL b2b_hold: got result change before second done, want first result %h held", r1);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int dones;
        data_in = 8'hA7; dir = 1'b0; amount = 4'd8; mode = 2'b10; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst_n = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        checks++;
        if ({ready, busy, done, result, carry} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0}) begin
            failures++;
            $display("FAIL reset_mid: got ready=%b busy=%b done=%b result=%h carry=%b, want 1 0 0 00 0",
                     ready, busy, done, result, carry);
        end
        rst_n = 1'b1;
        dones = 0;
        repeat (12) begin
            @(posedge clk);
            @(negedge clk);
            if (done || busy) dones++;
        end
        checks++;
        if (dones != 0) begin
            failures++;
            $display("FAIL reset_mid_abort: got %0d active cycles after reset, want 0", dones);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_directed();
        test_random();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
